// File: rtl/alu_issue.sv
// Execute-stage issue controller: decodes RV32I OP/OP-IMM into ALU controls, waits out the ALU latency, returns a writeback packet.
// Optional feature: define ALU_ISSUE_LUI_EN to accept LUI as an ADD of 0 and the upper immediate.
module alu_issue #(
    parameter int ALU_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_result,
    input  logic [4:0]  alu_status,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic        rd_we,
    output logic [4:0]  out_status,
    output logic        illegal
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [6:0] OPC_OP  = 7'b0110011;
    localparam logic [6:0] OPC_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI = 7'b0110111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] CNT_INIT = 3'(ALU_LATENCY);

    logic [1:0]  state_reg;
    logic [2:0]  cnt_reg;
    logic [31:0] alu_a_reg;
    logic [31:0] alu_b_reg;
    logic [3:0]  alu_op_reg;
    logic        out_valid_reg;
    logic [4:0]  rd_addr_reg;
    logic [31:0] rd_data_reg;
    logic        rd_we_reg;
    logic [4:0]  out_status_reg;
    logic        illegal_reg;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd_field;

    logic        dec_legal;
    logic [31:0] dec_a;
    logic [31:0] dec_b;
    logic [3:0]  dec_op;

    assign opcode   = instr[6:0];
    assign rd_field = instr[11:7];
    assign funct3   = instr[14:12];
    assign funct7   = instr[31:25];

    always_comb begin
        dec_legal = 1'b0;
        dec_a     = rs1_data;
        dec_b     = rs2_data;
        dec_op    = {instr[30], funct3};
        case (opcode)
            OPC_OP: begin
                dec_legal = (funct7 == F7_ZERO) ||
                            ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            end
            OPC_IMM: begin
                if ((funct3 == 3'b001) || (funct3 == 3'b101)) begin
                    dec_b     = {27'b0, instr[24:20]};
                    dec_op    = {instr[30], funct3};
                    dec_legal = (funct7 == F7_ZERO) || ((funct7 == F7_ALT) && (funct3 == 3'b101));
                end else begin
                    // instr[30] is immediate data here, so ADDI never turns into SUB
                    dec_b     = {{20{instr[31]}}, instr[31:20]};
                    dec_op    = {1'b0, funct3};
                    dec_legal = 1'b1;
                end
            end
`ifdef ALU_ISSUE_LUI_EN
            OPC_LUI: begin
                dec_a     = 32'd0;
                dec_b     = {instr[31:12], 12'b0};
                dec_op    = 4'b0000;
                dec_legal = 1'b1;
            end
`else
            OPC_LUI: begin
                dec_legal = 1'b0;
            end
`endif
            default: begin
                dec_legal = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= 3'd0;
            alu_a_reg      <= 32'd0;
            alu_b_reg      <= 32'd0;
            alu_op_reg     <= 4'd0;
            out_valid_reg  <= 1'b0;
            rd_addr_reg    <= 5'd0;
            rd_data_reg    <= 32'd0;
            rd_we_reg      <= 1'b0;
            out_status_reg <= 5'd0;
            illegal_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        rd_addr_reg <= rd_field;
                        if (dec_legal) begin
                            alu_a_reg   <= dec_a;
                            alu_b_reg   <= dec_b;
                            alu_op_reg  <= dec_op;
                            cnt_reg     <= CNT_INIT;
                            illegal_reg <= 1'b0;
                            rd_we_reg   <= (rd_field != 5'd0);
                            state_reg   <= ST_EXEC;
                        end else begin
                            // ALU is not issued: alu_* keep their previous values
                            illegal_reg    <= 1'b1;
                            rd_we_reg      <= 1'b0;
                            rd_data_reg    <= 32'd0;
                            out_status_reg <= 5'd0;
                            out_valid_reg  <= 1'b1;
                            state_reg      <= ST_RESP;
                        end
                    end
                end
                ST_EXEC: begin
                    if (cnt_reg == 3'd0) begin
                        rd_data_reg    <= alu_result;
                        out_status_reg <= alu_status;
                        out_valid_reg  <= 1'b1;
                        state_reg      <= ST_RESP;
                    end else begin
                        cnt_reg <= cnt_reg - 3'd1;
                    end
                end
                ST_RESP: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = (state_reg == ST_IDLE);
    assign alu_a      = alu_a_reg;
    assign alu_b      = alu_b_reg;
    assign alu_op     = alu_op_reg;
    assign out_valid  = out_valid_reg;
    assign rd_addr    = rd_addr_reg;
    assign rd_data    = rd_data_reg;
    assign rd_we      = rd_we_reg;
    assign out_status = out_status_reg;
    assign illegal    = illegal_reg;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: behavioural ALU with configurable latency, scoreboard of expected writeback packets.
module tb_alu_issue;

    localparam int L = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;
    logic [4:0]  alu_status;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_we;
    logic [4:0]  out_status;
    logic        illegal;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        we;
        logic [4:0]  st;
        logic        ill;
    } exp_t;

    exp_t sb[$];

    logic [31:0] exp_a = 32'd0;
    logic [31:0] exp_b = 32'd0;
    logic [3:0]  exp_op = 4'd0;

    always #5 clk = ~clk;

    alu_issue #(.ALU_LATENCY(L)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_status(alu_status),
        .out_valid(out_valid), .out_ready(out_ready), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_we(rd_we), .out_status(out_status), .illegal(illegal)
    );

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        case (op)
            4'b0000: return a + b;
            4'b1000: return a - b;
            4'b0001: return a << b[4:0];
            4'b0010: return {31'b0, $signed(a) < $signed(b)};
            4'b0011: return {31'b0, a < b};
            4'b0100: return a ^ b;
            4'b0101: return a >> b[4:0];
            4'b1101: return 32'($signed(a) >>> b[4:0]);
            4'b0110: return a | b;
            4'b0111: return a & b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [4:0] status_f(input logic [31:0] r);
        return {r == 32'd0, r[31], r[0], ^r, 1'b1};
    endfunction

    // ALU stand-in: result appears L edges after its inputs settle
    logic [31:0] pipe_r [L];
    logic [4:0]  pipe_s [L];
    always @(posedge clk) begin
        pipe_r[0] <= alu_f(alu_a, alu_b, alu_op);
        pipe_s[0] <= status_f(alu_f(alu_a, alu_b, alu_op));
        for (int i = 1; i < L; i++) begin
            pipe_r[i] <= pipe_r[i-1];
            pipe_s[i] <= pipe_s[i-1];
        end
    end
    assign alu_result = pipe_r[L-1];
    assign alu_status = pipe_s[L-1];

    function automatic logic [31:0] r_enc(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_enc(input logic [11:0] imm, input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm, 5'd1, f3, rd, opc};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input string name, input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2,
                         input logic legal, input logic [31:0] ea, input logic [31:0] eb,
                         input logic [3:0] eop, input logic [31:0] edata, input int hold);
        exp_t e;
        exp_t got;
        int cyc;
        logic [31:0] hd;
        logic [4:0]  hs;
        e.rd  = ins[11:7];
        e.we  = legal && (ins[11:7] != 5'd0);
        e.ill = !legal;
        if (legal) begin
            exp_a  = ea;
            exp_b  = eb;
            exp_op = eop;
            e.data = edata;
            e.st   = status_f(edata);
        end else begin
            e.data = 32'd0;
            e.st   = 5'd0;
        end
        sb.push_back(e);

        cyc = 0;
        while (!in_ready && cyc < 20) begin
            step();
            cyc++;
        end
        chk({name, ".in_ready_idle"}, 32'(in_ready), 32'd1);

        instr    = ins;
        rs1_data = r1;
        rs2_data = r2;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        instr    = $urandom;
        rs1_data = $urandom;
        rs2_data = $urandom;
        chk({name, ".alu_a"}, alu_a, exp_a);
        chk({name, ".alu_b"}, alu_b, exp_b);
        chk({name, ".alu_op"}, 32'(alu_op), 32'(exp_op));
        chk({name, ".in_ready_busy"}, 32'(in_ready), 32'd0);

        cyc = 1;
        while (!out_valid && cyc < 30) begin
            step();
            cyc++;
        end
        chk({name, ".latency"}, 32'(cyc), legal ? 32'(L + 2) : 32'd1);

        got = sb.pop_front();
        if (legal) chk({name, ".rd_addr"}, 32'(rd_addr), 32'(got.rd));
        chk({name, ".rd_data"}, rd_data, got.data);
        chk({name, ".rd_we"}, 32'(rd_we), 32'(got.we));
        chk({name, ".out_status"}, 32'(out_status), 32'(got.st));
        chk({name, ".illegal"}, 32'(illegal), 32'(got.ill));
        chk({name, ".alu_held"}, {alu_a ^ alu_b, 28'd0, alu_op}, {exp_a ^ exp_b, 28'd0, exp_op});

        hd = rd_data;
        hs = out_status;
        for (int i = 0; i < hold; i++) begin
            step();
            chk({name, ".bp_valid"}, 32'(out_valid), 32'd1);
            chk({name, ".bp_data"}, rd_data, hd);
            chk({name, ".bp_status"}, 32'(out_status), 32'(hs));
            chk({name, ".bp_in_ready"}, 32'(in_ready), 32'd0);
        end

        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({name, ".ready_after"}, 32'(in_ready), 32'd1);
        chk({name, ".valid_drop"}, 32'(out_valid), 32'd0);
        $display("txn %s instr=%h rd_data=%h illegal=%0b", name, ins, hd, illegal);
    endtask

    initial begin
        logic seen_valid;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        instr     = 32'd0;
        rs1_data  = 32'd0;
        rs2_data  = 32'd0;
        step();
        step();
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.pkt", {rd_data ^ alu_a ^ alu_b, 3'd0, rd_addr, out_status, rd_we, illegal, 14'd0, alu_op},
            32'd0);
        rst_n = 1'b1;
        step();

        issue("add",   r_enc(7'b0000000, 3'b000, 5'd3), 32'd9, 32'd10, 1'b1, 32'd9, 32'd10, 4'b0000, 32'd19, 0);
        issue("sub",   r_enc(7'b0100000, 3'b000, 5'd4), 32'd9, 32'd10, 1'b1, 32'd9, 32'd10, 4'b1000,
              32'hFFFF_FFFF, 0);
        issue("addi",  i_enc(12'hFFF, 3'b000, 5'd5, 7'b0010011), 32'd5, 32'h1234, 1'b1, 32'd5, 32'hFFFF_FFFF,
              4'b0000, 32'd4, 0);
        issue("srai",  i_enc({7'b0100000, 5'd4}, 3'b101, 5'd6, 7'b0010011), 32'h8000_0000, 32'd77, 1'b1,
              32'h8000_0000, 32'd4, 4'b1101, 32'hF800_0000, 5);
        issue("slli_bad", i_enc({7'b0100000, 5'd4}, 3'b001, 5'd7, 7'b0010011), 32'd1, 32'd2, 1'b0,
              0, 0, 0, 0, 0);
        issue("opc_bad", 32'h0000_007F, 32'd3, 32'd4, 1'b0, 0, 0, 0, 0, 2);
        issue("and_x0", r_enc(7'b0000000, 3'b111, 5'd0), 32'h0000_F0F0, 32'h0000_0FF0, 1'b1,
              32'h0000_F0F0, 32'h0000_0FF0, 4'b0111, 32'h0000_00F0, 0);
        issue("or",    r_enc(7'b0000000, 3'b110, 5'd7), 32'h0000_F0F0, 32'h0000_0FF0, 1'b1,
              32'h0000_F0F0, 32'h0000_0FF0, 4'b0110, 32'h0000_FFF0, 0);
        issue("xor",   r_enc(7'b0000000, 3'b100, 5'd8), 32'h0000_F0F0, 32'h0000_0FF0, 1'b1,
              32'h0000_F0F0, 32'h0000_0FF0, 4'b0100, 32'h0000_FF00, 0);
        issue("slt",   r_enc(7'b0000000, 3'b010, 5'd9), 32'hFFFF_FFFF, 32'd1, 1'b1, 32'hFFFF_FFFF, 32'd1,
              4'b0010, 32'd1, 0);
        issue("sltu",  r_enc(7'b0000000, 3'b011, 5'd10), 32'hFFFF_FFFF, 32'd1, 1'b1, 32'hFFFF_FFFF, 32'd1,
              4'b0011, 32'd0, 0);
        issue("sll",   r_enc(7'b0000000, 3'b001, 5'd11), 32'd1, 32'h25, 1'b1, 32'd1, 32'h25, 4'b0001,
              32'h20, 0);
        issue("srl",   r_enc(7'b0000000, 3'b101, 5'd12), 32'h8000_0000, 32'd4, 1'b1, 32'h8000_0000, 32'd4,
              4'b0101, 32'h0800_0000, 0);
        issue("sra",   r_enc(7'b0100000, 3'b101, 5'd13), 32'h8000_0000, 32'd4, 1'b1, 32'h8000_0000, 32'd4,
              4'b1101, 32'hF800_0000, 0);
        issue("addi_b30", i_enc(12'h400, 3'b000, 5'd14, 7'b0010011), 32'd1, 32'd9, 1'b1, 32'd1, 32'h400,
              4'b0000, 32'h401, 0);
        issue("ori",   i_enc(12'h800, 3'b110, 5'd15, 7'b0010011), 32'd0, 32'd9, 1'b1, 32'd0, 32'hFFFF_F800,
              4'b0110, 32'hFFFF_F800, 0);
        issue("or_f7bad", r_enc(7'b0100000, 3'b110, 5'd16), 32'd1, 32'd2, 1'b0, 0, 0, 0, 0, 0);
        issue("mul_bad", r_enc(7'b0000001, 3'b000, 5'd17), 32'd1, 32'd2, 1'b0, 0, 0, 0, 0, 0);
        issue("srai_bad", i_enc({7'b0000001, 5'd3}, 3'b101, 5'd18, 7'b0010011), 32'd1, 32'd2, 1'b0,
              0, 0, 0, 0, 0);
`ifdef ALU_ISSUE_LUI_EN
        issue("lui",   {20'h12345, 5'd5, 7'b0110111}, 32'd7, 32'd8, 1'b1, 32'd0, 32'h1234_5000, 4'b0000,
              32'h1234_5000, 0);
`else
        issue("lui",   {20'h12345, 5'd5, 7'b0110111}, 32'd7, 32'd8, 1'b0, 0, 0, 0, 0, 0);
`endif

        // reset lands one edge after the accept; the dropped instruction must never report
        instr    = r_enc(7'b0000000, 3'b000, 5'd3);
        rs1_data = 32'd100;
        rs2_data = 32'd23;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("rstx.accepted", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rstx.in_ready", 32'(in_ready), 32'd1);
        chk("rstx.out_valid", 32'(out_valid), 32'd0);
        chk("rstx.pkt", {rd_data ^ alu_a ^ alu_b, 3'd0, rd_addr, out_status, rd_we, illegal, 14'd0, alu_op},
            32'd0);
        seen_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (out_valid) seen_valid = 1'b1;
        end
        chk("rstx.no_valid", 32'(seen_valid), 32'd0);
        chk("rstx.idle", 32'(in_ready), 32'd1);
        $display("txn rst_mid_exec out_valid_seen=%0b", seen_valid);

        issue("add_after_rst", r_enc(7'b0000000, 3'b000, 5'd3), 32'd100, 32'd23, 1'b1, 32'd100, 32'd23,
              4'b0000, 32'd123, 0);
        chk("sb.empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
